dual_core_mem_arbiter: RTL

- Shares one data-memory port between the two pipeline cores of the multi-core CPU.
- Each core's MEM stage raises a request and holds its pipeline via a stall output until the access completes.
- The stall output ORs into that core's PC-write / IF_ID-hold / flush logic in the same way a load-use stall does.
- Arbitration is round-robin. Memory latency is fixed by a parameter.

---
 rtl/dual_core_mem_arbiter_if.sv | 42 ++++
 rtl/dual_core_mem_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/dual_core_mem_arbiter_if.sv
// dual_core_mem_arbiter_if: core request/response and shared memory port bundle
interface dual_core_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c0_req_i;
    logic              c0_we_i;
    logic [ADDR_W-1:0] c0_addr_i;
    logic [DATA_W-1:0] c0_wdata_i;
    logic [DATA_W-1:0] c0_rdata_o;
    logic              c0_done_o;
    logic              c0_stall_o;
    logic              c1_req_i;
    logic              c1_we_i;
    logic [ADDR_W-1:0] c1_addr_i;
    logic [DATA_W-1:0] c1_wdata_i;
    logic [DATA_W-1:0] c1_rdata_o;
    logic              c1_done_o;
    logic              c1_stall_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              owner_o;
    modport slave (
        input  c0_req_i, c0_we_i, c0_addr_i, c0_wdata_i,
        input  c1_req_i, c1_we_i, c1_addr_i, c1_wdata_i,
        input  mem_rdata_i,
        output c0_rdata_o, c0_done_o, c0_stall_o,
        output c1_rdata_o, c1_done_o, c1_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, owner_o
    );
    modport master (
        output c0_req_i, c0_we_i, c0_addr_i, c0_wdata_i,
        output c1_req_i, c1_we_i, c1_addr_i, c1_wdata_i,
        output mem_rdata_i,
        input  c0_rdata_o, c0_done_o, c0_stall_o,
        input  c1_rdata_o, c1_done_o, c1_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, owner_o
    );
endinterface

// File: rtl/dual_core_mem_arbiter.sv
// dual_core_mem_arbiter: round-robin sharing of one fixed-latency data-memory port between two cores
module dual_core_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input logic clk_i,
    input logic rst_i,
    dual_core_mem_arbiter_if.slave bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    logic [1:0]        r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_any;
    logic              w_pick;
    logic              w_access;
    logic              w_done0;
    logic              w_done1;
    logic              w_capture;
    assign w_any     = bus.c0_req_i | bus.c1_req_i;
    assign w_pick    = (bus.c0_req_i & bus.c1_req_i) ? ~r_last : bus.c1_req_i;
    assign w_access  = r_state == S_ACCESS;
    assign w_done0   = r_state == S_DONE && !r_owner;
    assign w_done1   = r_state == S_DONE && r_owner;
    assign w_capture = w_access && r_cnt == '0 && !r_we;
    // grant, latch the winner's request, count out the memory latency, then pulse done
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_owner <= w_pick;
                    r_we    <= w_pick ? bus.c1_we_i : bus.c0_we_i;
                    r_addr  <= w_pick ? bus.c1_addr_i : bus.c0_addr_i;
                    r_wdata <= w_pick ? bus.c1_wdata_i : bus.c0_wdata_i;
                    r_cnt   <= CNT_W'(MEM_LAT - 1);
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_last  <= r_owner;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    // load data lands in the owner's register on the last access cycle and holds until its next load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (w_capture) begin
            if (r_owner) r_rdata1 <= bus.mem_rdata_i;
            else r_rdata0 <= bus.mem_rdata_i;
        end
    end
    assign bus.mem_en_o    = w_access;
    assign bus.mem_we_o    = w_access & r_we;
    assign bus.mem_addr_o  = w_access ? r_addr : '0;
    assign bus.mem_wdata_o = w_access ? r_wdata : '0;
    assign bus.owner_o     = r_owner;
    assign bus.c0_done_o   = w_done0;
    assign bus.c1_done_o   = w_done1;
    assign bus.c0_stall_o  = bus.c0_req_i & ~w_done0;
    assign bus.c1_stall_o  = bus.c1_req_i & ~w_done1;
    assign bus.c0_rdata_o  = r_rdata0;
    assign bus.c1_rdata_o  = r_rdata1;
endmodule
